// File: rtl/dmux_1by8_sf.sv
// 1:8 demultiplexer built as a three-level tree of 1:2 AND-gate cells, with a
// registered copy of the outputs and of the select.
module dmux_1by8_sf #(
  parameter int unsigned DATA_W = 1
) (
  output logic [8*DATA_W-1:0] y,
  input  logic [2:0]          s,
  input  logic [DATA_W-1:0]   i,
  input  logic                clk,
  input  logic                rst_n,
  output logic [8*DATA_W-1:0] y_r,
  output logic [2:0]          sel_r
);

  // Tree nodes: the index at each level is the select prefix decoded so far,
  // so the leaf index equals {s[2], s[1], s[0]}.
  logic [DATA_W-1:0] lvl1 [2];
  logic [DATA_W-1:0] lvl2 [4];
  logic [DATA_W-1:0] lvl3 [8];

  // Root cell, steered by s[2].
  assign lvl1[0] = i & ~{DATA_W{s[2]}};
  assign lvl1[1] = i &  {DATA_W{s[2]}};

  // Middle cells, steered by s[1].
  for (genvar j = 0; j < 2; j++) begin : g_mid
    assign lvl2[2*j]   = lvl1[j] & ~{DATA_W{s[1]}};
    assign lvl2[2*j+1] = lvl1[j] &  {DATA_W{s[1]}};
  end

  // Leaf cells, steered by s[0].
  for (genvar m = 0; m < 4; m++) begin : g_leaf
    assign lvl3[2*m]   = lvl2[m] & ~{DATA_W{s[0]}};
    assign lvl3[2*m+1] = lvl2[m] &  {DATA_W{s[0]}};
  end

  // Pack leaves into the flat output bus, channel k at y[k*DATA_W +: DATA_W].
  for (genvar k = 0; k < 8; k++) begin : g_pack
    assign y[k*DATA_W +: DATA_W] = lvl3[k];
  end

  // Registered copy of y and s; cleared asynchronously while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r   <= '0;
      sel_r <= '0;
    end else begin
      y_r   <= y;
      sel_r <= s;
    end
  end

endmodule

// File: tb/tb_dmux_1by8_sf.sv
// Self-checking bench for dmux_1by8_sf: directed vectors, literal expectations,
// and a per-cycle comparison against a shift-based behavioural model.
module tb_dmux_1by8_sf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  s1;
  logic        i1;
  logic [2:0]  s4;
  logic [3:0]  i4;

  logic [7:0]  y1, yr1, ync, yrnc;
  logic [2:0]  selr1, selr4, selrnc;
  logic [31:0] y4, yr4;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  dmux_1by8_sf #(.DATA_W(1)) dut1 (
    .y(y1), .s(s1), .i(i1), .clk(clk), .rst_n(rst_n), .y_r(yr1), .sel_r(selr1)
  );

  dmux_1by8_sf #(.DATA_W(4)) dut4 (
    .y(y4), .s(s4), .i(i4), .clk(clk), .rst_n(rst_n), .y_r(yr4), .sel_r(selr4)
  );

  // Instance with clock and reset tied off: y must still work on its own.
  dmux_1by8_sf #(.DATA_W(1)) dut_nc (
    .y(ync), .s(s1), .i(i1), .clk(1'b0), .rst_n(1'b0), .y_r(yrnc), .sel_r(selrnc)
  );

  function automatic logic [7:0] model1(input logic [2:0] sel, input logic d);
    logic [7:0] v;
    v = {7'b0, d};
    return v << sel;
  endfunction

  function automatic logic [31:0] model4(input logic [2:0] sel, input logic [3:0] d);
    logic [31:0] v;
    v = {28'b0, d};
    return v << (32'(sel) * 4);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Expected registered outputs: capture the model at each rising edge.
  logic [7:0]  exp_yr1 = '0;
  logic [2:0]  exp_sel1 = '0;
  logic [31:0] exp_yr4 = '0;
  logic [2:0]  exp_sel4 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_yr1  <= '0;
      exp_sel1 <= '0;
      exp_yr4  <= '0;
      exp_sel4 <= '0;
    end else begin
      exp_yr1  <= model1(s1, i1);
      exp_sel1 <= s1;
      exp_yr4  <= model4(s4, i4);
      exp_sel4 <= s4;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!done) begin
      check("cyc_y1", 32'(y1), 32'(model1(s1, i1)));
      check("cyc_yr1", 32'(yr1), 32'(exp_yr1));
      check("cyc_sel1", 32'(selr1), 32'(exp_sel1));
      check("cyc_y4", y4, model4(s4, i4));
      check("cyc_yr4", yr4, exp_yr4);
      check("cyc_sel4", 32'(selr4), 32'(exp_sel4));
      check("cyc_ync", 32'(ync), 32'(model1(s1, i1)));
      check("cyc_nc_regs", {21'b0, selrnc, yrnc}, 32'h0);
    end
  end

  logic [7:0] onehot [8];
  logic [2:0] vs [6];
  logic       vi [6];

  initial begin
    onehot = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    vs = '{3'd7, 3'd0, 3'd4, 3'd2, 3'd6, 3'd1};
    vi = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0;
    s1 = '0; i1 = 1'b0; s4 = '0; i4 = '0;
    #1;
    check("reset_yr1", 32'(yr1), 32'h0);
    check("reset_sel1", 32'(selr1), 32'h0);
    check("reset_yr4", yr4, 32'h0);

    // One-hot step while reset is held: y is independent of reset.
    i1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s1 = 3'(k);
      #1;
      check("onehot_y1", 32'(y1), 32'(onehot[k]));
      check("onehot_ync", 32'(ync), 32'(onehot[k]));
      check("onehot_reset_yr1", 32'(yr1), 32'h0);
      #9;
    end

    // Zero data gives all-zero outputs for every select.
    i1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s1 = 3'(k);
      #1;
      check("zero_y1", 32'(y1), 32'h0);
      #9;
    end

    // Release reset between edges; the next rising edge loads normally.
    @(negedge clk);
    #2 rst_n = 1'b1;
    s1 = 3'b101; i1 = 1'b1;
    @(posedge clk);
    #1;
    check("load_yr1", 32'(yr1), 32'h20);
    check("load_sel1", 32'(selr1), 32'h5);

    // Mid-cycle asynchronous reset.
    #2 rst_n = 1'b0;
    #0.5;
    check("async_yr1", 32'(yr1), 32'h0);
    check("async_sel1", 32'(selr1), 32'h0);
    check("async_y1", 32'(y1), 32'h20);
    #0.5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reload_yr1", 32'(yr1), 32'h20);
    check("reload_sel1", 32'(selr1), 32'h5);

    // Wide data, literal pin of the model.
    @(negedge clk);
    #2 s4 = 3'd3; i4 = 4'hA;
    #1;
    check("wide_literal", y4, 32'h0000A000);

    // Sweep all selects with random nonzero data on the wide instance.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #2 s4 = 3'(k); i4 = 4'($urandom_range(1, 15));
      #1;
      for (int c = 0; c < 8; c++) begin
        check("wide_chan", 32'(y4[c*4 +: 4]), (c == k) ? 32'(i4) : 32'h0);
      end
    end

    // Directed select/data changes on the narrow instance, one per cycle.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #2 s1 = vs[k]; i1 = vi[k];
    end

    @(negedge clk);
    @(negedge clk);
    #1 done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
